// File: rtl/softmax_frame_ctrl.sv
// Frame sequencer for the softmax log-sum-exp pipeline: buffers one frame, starts and feeds the
// pipeline, then holds the ln result for downstream. Optional WAIT timeout: SOFTMAX_CTRL_TIMEOUT_EN.
module softmax_frame_ctrl #(
  parameter int DATA_SIZE      = 32,
  parameter int NUMBER_OF_DATA = 10
`ifdef SOFTMAX_CTRL_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 256
`endif
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic [DATA_SIZE-1:0] in_data_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  output logic                 pipe_start_o,
  output logic [DATA_SIZE-1:0] pipe_data_o,
  output logic                 pipe_data_valid_o,
  input  logic [DATA_SIZE-1:0] pipe_ln_data_i,
  input  logic                 pipe_ln_valid_i,
  output logic [DATA_SIZE-1:0] result_o,
  output logic                 result_valid_o,
  input  logic                 result_ready_i,
  output logic                 busy_o,
  output logic                 error_o,
  output logic [15:0]          frame_cnt_o,
  output logic [2:0]           state_o
);

  // Both streams use valid/ready: a word or result moves on a rising edge where valid and ready
  // are both high; valid is held and its payload kept stable until that edge.
  localparam int CW = $clog2(NUMBER_OF_DATA);

  localparam logic [2:0] S_LOAD  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_FEED  = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]           state;
  logic [CW-1:0]        wr_cnt;
  logic [CW-1:0]        rd_cnt;
  logic [DATA_SIZE-1:0] frame_buf [NUMBER_OF_DATA];
  logic [DATA_SIZE-1:0] last_word;
  logic [DATA_SIZE-1:0] result_q;
  logic [15:0]          frame_cnt;
  logic                 accept;
  logic                 timed_out;

  assign in_ready_o = (state == S_LOAD) && !reset_i;
  assign accept     = in_valid_i && in_ready_o;

  always_ff @(posedge clock_i) begin
    if (accept) frame_buf[wr_cnt] <= in_data_i;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state     <= S_LOAD;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      last_word <= '0;
      result_q  <= '0;
      frame_cnt <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          if (accept) begin
            if (wr_cnt == CW'(NUMBER_OF_DATA - 1)) begin
              wr_cnt <= '0;
              state  <= S_START;
            end else begin
              wr_cnt <= wr_cnt + CW'(1);
            end
          end
        end
        S_START: state <= S_FEED;
        S_FEED: begin
          // Remember the word on the bus so it stays put while waiting for ln.
          last_word <= frame_buf[rd_cnt];
          if (rd_cnt == CW'(NUMBER_OF_DATA - 1)) begin
            rd_cnt <= '0;
            state  <= S_WAIT;
          end else begin
            rd_cnt <= rd_cnt + CW'(1);
          end
        end
        S_WAIT: begin
          if (pipe_ln_valid_i) begin
            result_q <= pipe_ln_data_i;
            state    <= S_DONE;
          end else if (timed_out) begin
            result_q <= '0;
            state    <= S_DONE;
          end
        end
        S_DONE: begin
          if (result_ready_i) begin
            frame_cnt <= frame_cnt + 16'd1;
            state     <= S_LOAD;
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

`ifdef SOFTMAX_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] wait_cnt;
  logic          error_q;

  // A same-cycle ln pulse takes priority over the limit.
  assign timed_out = (state == S_WAIT) && !pipe_ln_valid_i &&
                     (wait_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wait_cnt <= '0;
      error_q  <= 1'b0;
    end else begin
      if (state != S_WAIT) wait_cnt <= '0;
      else                 wait_cnt <= wait_cnt + TW'(1);

      if (state == S_WAIT && pipe_ln_valid_i)     error_q <= 1'b0;
      else if (timed_out)                         error_q <= 1'b1;
      else if (state == S_DONE && result_ready_i) error_q <= 1'b0;
    end
  end

  assign error_o = error_q;
`else
  assign timed_out = 1'b0;
  assign error_o   = 1'b0;
`endif

  assign pipe_start_o      = (state == S_START);
  assign pipe_data_valid_o = (state == S_FEED);
  assign pipe_data_o       = (state == S_FEED) ? frame_buf[rd_cnt] : last_word;
  assign result_o          = result_q;
  assign result_valid_o    = (state == S_DONE);
  assign busy_o            = (state != S_LOAD);
  assign frame_cnt_o       = frame_cnt;
  assign state_o           = state;

endmodule
